uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 140 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchronized rx, mid-bit sampling, optional parity,
// 1 or 2 stop bits. Results are loaded and done_rx pulses one cycle after the last stop sample.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_rx,
    output logic                 done_rx,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int TW       = $clog2(BAUD_DIV + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s;
    logic [TW-1:0]        timer;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit, stop_bad, fin;
    logic                 tick, last_data, last_stop, par_calc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // START samples at the half-bit point; every later bit is sampled one full bit period on.
    assign tick      = (state == START) ? (timer == TW'(HALF - 1)) : (timer == TW'(BAUD_DIV - 1));
    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
    assign busy      = (state != IDLE);

    always_comb begin
        par_calc = 1'b0;
        if (PARITY == 1)
            par_calc = ((^shreg) ^ par_bit) != 1'b1;
        else if (PARITY == 2)
            par_calc = ((^shreg) ^ par_bit) != 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (tick) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (tick && last_data) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:     if (tick) state_nxt = STOP;
            STOP:    if (fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            stop_bad   <= 1'b0;
            fin        <= 1'b0;
            data_rx    <= '0;
            done_rx    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            done_rx <= 1'b0;
            case (state)
                IDLE: begin
                    timer    <= '0;
                    bit_cnt  <= '0;
                    stop_bad <= 1'b0;
                    fin      <= 1'b0;
                end
                START: begin
                    timer <= tick ? '0 : timer + TW'(1);
                end
                DATA: begin
                    if (tick) begin
                        timer   <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                PAR: begin
                    if (tick) begin
                        timer   <= '0;
                        par_bit <= rx_s;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    // fin marks the cycle after the final stop sample, when results are published.
                    if (fin) begin
                        data_rx    <= shreg;
                        parity_err <= par_calc;
                        frame_err  <= stop_bad;
                        done_rx    <= 1'b1;
                        fin        <= 1'b0;
                    end else if (tick) begin
                        timer <= '0;
                        if (!rx_s) stop_bad <= 1'b1;
                        if (last_stop) fin <= 1'b1;
                        else bit_cnt <= bit_cnt + 4'd1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: timer <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations share one clock/reset; frames are checked
// against a reference built from the frame format and the documented done_rx latency.
module tb_uart_rx_cfg;

  localparam int CLK_FREQ = 1600;
  localparam int BAUD     = 100;
  localparam int B        = CLK_FREQ / BAUD;
  localparam int HALF     = B / 2;
  localparam int EW       = 45;

  int db_cfg[3]  = '{8, 7, 8};
  int par_cfg[3] = '{0, 2, 1};
  int sb_cfg[3]  = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx_line = 3'b111;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic [2:0] done, perr, ferr, busy;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[0]), .data_rx(d0), .done_rx(done[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .busy(busy[0]));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[1]), .data_rx(d1), .done_rx(done[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .busy(busy[1]));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[2]), .data_rx(d2), .done_rx(done[2]),
    .parity_err(perr[2]), .frame_err(ferr[2]), .busy(busy[2]));

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired, expected completion earlier");
    $fatal(1, "watchdog");
  end

  // checking
  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [8:0] dout(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {2'b0, d1};
      default: return {1'b0, d2};
    endcase
  endfunction

  // scoreboard: {inst[1:0], data[8:0], parity_err, frame_err, done cycle[31:0]}
  logic [EW-1:0] exp_q[$];
  logic [8:0]    last_data[3] = '{9'h0, 9'h0, 9'h0};
  logic [EW-1:0] e;
  logic [2:0]    done_prev = 3'b000;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) begin
        check("done_width", done_prev[i], 0);
        if (exp_q.size() == 0) begin
          check("spurious_done", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("done_inst", i, e[44:43]);
          check("data_rx", dout(i), e[42:34]);
          check("parity_err", perr[i], e[33]);
          check("frame_err", ferr[i], e[32]);
          check("done_cycle", cyc, e[31:0]);
          last_data[i] = e[42:34];
        end
      end
    end
    done_prev = done;
  end

  // driver
  task automatic drive_bit(input int i, input logic b);
    rx_line[i] = b;
    repeat (B) @(negedge clk);
  endtask

  // Called just after a negedge; the next posedge is the first to see the start bit.
  task automatic send_frame(input int i, input logic [8:0] data, input bit flip,
                            input logic [1:0] stop_v, input int gap);
    int k, nbits, expcyc;
    logic [8:0] d;
    logic pbit, fe;
    k      = cyc + 1;
    d      = data & ((9'h1 << db_cfg[i]) - 9'h1);
    nbits  = db_cfg[i] + ((par_cfg[i] != 0) ? 1 : 0) + sb_cfg[i];
    pbit   = ((par_cfg[i] == 2) ? (^d) : ~(^d)) ^ flip;
    fe     = (stop_v[0] == 1'b0) || ((sb_cfg[i] == 2) && (stop_v[1] == 1'b0));
    expcyc = k + 2 + HALF + nbits * B + 1;
    exp_q.push_back({2'(i), d, (par_cfg[i] != 0) && flip, fe, 32'(expcyc)});
    drive_bit(i, 1'b0);
    for (int j = 0; j < db_cfg[i]; j++) drive_bit(i, d[j]);
    if (par_cfg[i] != 0) drive_bit(i, pbit);
    for (int j = 0; j < sb_cfg[i]; j++) drive_bit(i, stop_v[j]);
    rx_line[i] = 1'b1;
    repeat (gap * B) @(negedge clk);
  endtask

  initial begin
    int g;
    logic [7:0] partial;
    logic [1:0] sv;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_data0", d0, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {perr, ferr}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed frames
    send_frame(0, 9'hAC, 1'b0, 2'b11, 1);
    send_frame(0, 9'h55, 1'b0, 2'b10, 1);
    send_frame(0, 9'h0F, 1'b0, 2'b11, 1);
    send_frame(1, 9'h41, 1'b0, 2'b11, 1);
    send_frame(1, 9'h41, 1'b1, 2'b11, 1);
    send_frame(2, 9'hFF, 1'b0, 2'b01, 1);
    send_frame(2, 9'h5A, 1'b0, 2'b11, 1);

    // short low glitch on idle line: false start, no frame
    g = $urandom_range(3, HALF);
    rx_line[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_hi", busy[0], 1);
    repeat (g - 3) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (HALF + 4) @(negedge clk);
    check("glitch_busy_lo", busy[0], 0);
    check("glitch_data", dout(0), last_data[0]);

    // randomized frames
    for (int n = 0; n < 18; n++) begin
      int i;
      i  = $urandom_range(0, 2);
      sv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_frame(i, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), sv,
                 (sv != 2'b11) ? $urandom_range(1, 2) : $urandom_range(0, 2));
    end

    // reset in the middle of data bit 4
    partial = 8'($urandom_range(0, 255));
    rx_line[0] = 1'b0;
    repeat (B) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      rx_line[0] = partial[j];
      repeat (B) @(negedge clk);
    end
    rx_line[0] = partial[4];
    repeat (HALF) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_data", {d0, d1, d2}, 0);
    check("midrst_flags", {done, perr, ferr}, 0);
    rx_line = 3'b111;
    last_data = '{9'h0, 9'h0, 9'h0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("postrst_data", dout(0), 0);
    send_frame(0, 9'h3C, 1'b0, 2'b11, 1);

    repeat (4 * B) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
